// File: rtl/btn_tx_scheduler.sv
// Round-robin scheduler feeding push-button request bytes to a single transmitter.
// tx_start is issued one cycle after a request is seen in IDLE; frames are spaced by a busy handshake plus GAP_CYCLES.
module btn_tx_scheduler #(
    parameter int GAP_CYCLES = 16,
    parameter int START_TMO  = 8
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [3:0]  req_pulse,
    input  logic [31:0] req_data,
    input  logic        clr_err,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic [1:0]  grant_id,
    output logic [3:0]  pending,
    output logic [3:0]  overrun,
    output logic        tmo_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [7:0]  w_cnt_inc;
    logic [1:0]  r_rr_ptr;
    logic [1:0]  r_grant;
    logic [7:0]  r_tx_data;
    logic [3:0]  r_pending;
    logic [3:0]  r_overrun;
    logic        r_tmo;
    logic [1:0]  w_winner;
    logic        w_found;
    logic        w_load;
    logic        w_tmo_hit;
    logic [3:0]  w_clr_mask;
    logic [7:0]  w_slice;

    assign w_load    = (r_state == S_LOAD);
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    // First pending line at or after the pointer, wrapping around.
    always_comb begin
        logic [1:0] v_idx;
        w_winner = r_rr_ptr;
        w_found  = 1'b0;
        v_idx    = r_rr_ptr;
        for (int i = 0; i < 4; i++) begin
            v_idx = r_rr_ptr + 2'(i);
            if (!w_found && r_pending[v_idx]) begin
                w_winner = v_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign w_slice    = req_data[{w_winner, 3'b000} +: 8];
    assign w_clr_mask = w_load ? (4'b0001 << w_winner) : 4'b0000;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tmo_hit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_pending) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = S_WAIT_BUSY;
                w_cnt_nxt   = 8'd0;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_cnt == 8'(START_TMO - 1)) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = 8'd0;
                    w_tmo_hit   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_GAP: begin
                if (r_cnt == 8'(GAP_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_rr_ptr  <= 2'd0;
            r_grant   <= 2'd0;
            r_tx_data <= 8'd0;
            r_pending <= 4'd0;
            r_overrun <= 4'd0;
            r_tmo     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            // A fresh pulse on the line being granted re-arms it instead of counting as overrun.
            r_pending <= (r_pending & ~w_clr_mask) | req_pulse;
            r_overrun <= (clr_err ? 4'd0 : r_overrun) | (req_pulse & r_pending & ~w_clr_mask);
            r_tmo     <= (clr_err ? 1'b0 : r_tmo) | w_tmo_hit;
            if (w_load) begin
                r_grant   <= w_winner;
                r_tx_data <= w_slice;
                r_rr_ptr  <= w_winner + 2'd1;
            end
        end
    end

    assign tx_start = w_load;
    assign tx_data  = w_load ? w_slice : r_tx_data;
    assign grant_id = w_load ? w_winner : r_grant;
    assign pending  = r_pending;
    assign overrun  = r_overrun;
    assign tmo_err  = r_tmo;

endmodule

// File: tb/tb_btn_tx_scheduler.sv
// Randomized bench for btn_tx_scheduler against a frame-timing reference model.
module tb_btn_tx_scheduler;

    localparam int GAP = 16;
    localparam int TMO = 8;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_pulse = 4'd0;
    logic [31:0] req_data = 32'd0;
    logic        clr_err = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic [3:0]  pending;
    logic [3:0]  overrun;
    logic        tmo_err;

    always #5 clk_in = ~clk_in;

    btn_tx_scheduler #(.GAP_CYCLES(GAP), .START_TMO(TMO)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .req_pulse (req_pulse),
        .req_data  (req_data),
        .clr_err   (clr_err),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .grant_id  (grant_id),
        .pending   (pending),
        .overrun   (overrun),
        .tmo_err   (tmo_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: request bookkeeping plus absolute cycle numbers of frame events.
    int          cyc = 0;
    logic [3:0]  m_pend;
    logic [3:0]  m_ovr;
    logic        m_tmo;
    logic [1:0]  m_last;
    logic [1:0]  m_grant;
    logic [7:0]  m_txd;
    int          m_idle_at;
    int          m_load_at;
    int          m_tmo_at;
    int          b_start;
    int          b_end;
    int          tx_mode = 3;   // 0 random, 1 fixed 2/10, 2 never busy, 3 always answers

    function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] last);
        for (int s = 1; s <= 4; s++) begin
            int idx;
            idx = (int'(last) + s) % 4;
            if (p[idx]) return 2'(idx);
        end
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_pend    = 4'd0;
        m_ovr     = 4'd0;
        m_tmo     = 1'b0;
        m_last    = 2'd3;
        m_grant   = 2'd0;
        m_txd     = 8'd0;
        m_idle_at = cyc;
        m_load_at = -1;
        m_tmo_at  = -1;
        b_start   = -1;
        b_end     = -1;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n     = 1'b0;
        req_pulse = 4'd0;
        clr_err   = 1'b0;
        tx_busy   = 1'b0;
        #1;
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data",  32'(tx_data),  32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_pending",  32'(pending),  32'd0);
        chk("rst_overrun",  32'(overrun),  32'd0);
        chk("rst_tmo_err",  32'(tmo_err),  32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        cyc += 2;
        model_reset();
    endtask

    task automatic step(input logic [3:0] pulse, input logic [31:0] data, input logic clr);
        logic       exp_start;
        logic [1:0] win;
        logic [1:0] exp_grant;
        logic [7:0] exp_txd;
        logic [3:0] clr_mask;
        logic [3:0] nxt_pend;
        int         d;
        int         len;
        @(negedge clk_in);
        req_pulse = pulse;
        req_data  = data;
        clr_err   = clr;
        tx_busy   = (cyc >= b_start) && (cyc < b_end);
        exp_start = (cyc == m_load_at);
        win       = rr_pick(m_pend, m_last);
        exp_grant = exp_start ? win : m_grant;
        exp_txd   = exp_start ? data[int'(win) * 8 +: 8] : m_txd;
        #1;
        chk("tx_start", 32'(tx_start), 32'(exp_start));
        chk("grant_id", 32'(grant_id), 32'(exp_grant));
        chk("tx_data",  32'(tx_data),  32'(exp_txd));
        chk("pending",  32'(pending),  32'(m_pend));
        chk("overrun",  32'(overrun),  32'(m_ovr));
        chk("tmo_err",  32'(tmo_err),  32'(m_tmo));

        clr_mask = exp_start ? (4'b0001 << win) : 4'b0000;
        nxt_pend = (m_pend & ~clr_mask) | pulse;
        m_ovr    = (clr ? 4'd0 : m_ovr) | (pulse & m_pend & ~clr_mask);
        m_tmo    = (clr ? 1'b0 : m_tmo) | (cyc == m_tmo_at);
        if (exp_start) begin
            m_grant   = win;
            m_last    = win;
            m_txd     = exp_txd;
            m_load_at = -1;
            if (tx_mode == 2 || (tx_mode == 0 && $urandom_range(0, 5) == 0)) begin
                b_start   = -1;
                b_end     = -1;
                m_tmo_at  = cyc + TMO;
                m_idle_at = cyc + TMO + 1 + GAP;
            end else begin
                if (tx_mode == 1) begin
                    d   = 2;
                    len = 10;
                end else begin
                    d   = $urandom_range(1, TMO);
                    len = $urandom_range(1, 6);
                end
                b_start   = cyc + d;
                b_end     = cyc + d + len;
                m_idle_at = cyc + d + len + 1 + GAP;
            end
        end else if (m_load_at < 0 && cyc >= m_idle_at && m_pend != 4'd0) begin
            m_load_at = cyc + 1;
        end
        m_pend = nxt_pend;
        cyc++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reached;
        model_reset();
        do_reset();

        // Single request, transmitter answers 2 cycles after start for 10 cycles.
        tx_mode = 1;
        step(4'b0001, 32'h0000_0041, 1'b0);
        for (int i = 0; i < 39; i++) step(4'b0000, 32'h0000_0041, 1'b0);

        // All four at once: grants 0,1,2,3 with minimum spacing when the transmitter is prompt.
        tx_mode = 3;
        step(4'b1111, 32'h4443_4241, 1'b0);
        for (int i = 0; i < 150; i++) step(4'b0000, 32'h4443_4241, 1'b0);

        // Duplicate requests on line 1 while it is already pending, then clear.
        step(4'b0001, 32'h0000_5500, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0000, 32'h0000_5500, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 32'h0000_5500, 1'b0);
            step(4'b0000, 32'h0000_5500, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(4'b0000, 32'h0000_5500, 1'b0);
        step(4'b0000, 32'h0000_5500, 1'b1);
        for (int i = 0; i < 80; i++) step(4'b0000, 32'h0000_5500, 1'b0);

        // Transmitter never answers: timeout, gap, then the other pending line.
        tx_mode = 2;
        step(4'b0101, 32'h0033_0011, 1'b0);
        for (int i = 0; i < 80; i++) step(4'b0000, 32'h0033_0011, 1'b0);
        step(4'b0000, 32'h0033_0011, 1'b1);

        tx_mode = 0;
        for (int i = 0; i < 2500; i++) begin
            logic [3:0] p;
            for (int b = 0; b < 4; b++) p[b] = ($urandom_range(0, 15) == 0);
            step(p, $urandom, ($urandom_range(0, 31) == 0));
        end

        tx_mode = 3;
        for (int i = 0; i < 200; i++) step(4'b0000, $urandom, 1'b0);

        // Reset while the transmitter is busy and line 3 is pending again.
        tx_mode = 1;
        b_start = -1;
        b_end   = -1;
        step(4'b1000, 32'hA5A5_A5A5, 1'b0);
        reached = 0;
        for (int w = 0; w < 100 && reached == 0; w++) begin
            if (b_start >= 0 && cyc > b_start + 1) reached = 1;
            else step(4'b0000, 32'hA5A5_A5A5, 1'b0);
        end
        chk("reach_wait_done", 32'(reached), 32'd1);
        step(4'b1000, 32'hA5A5_A5A5, 1'b0);
        step(4'b0000, 32'hA5A5_A5A5, 1'b0);
        do_reset();
        for (int i = 0; i < 30; i++) step(4'b0000, $urandom, 1'b0);
        step(4'b0100, 32'h00C3_0000, 1'b0);
        for (int i = 0; i < 40; i++) step(4'b0000, 32'h00C3_0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_tx_scheduler.md
BTN_TX_SCHEDULER -- requirements
Module: btn_tx_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 16: idle cycles enforced between consecutive frames; legal range 1..255.
REQ-002 Parameter START_TMO, default 8: cycles allowed for tx_busy to rise after tx_start; legal range 2..255.
REQ-003 clk_in  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_pulse  input  4  one-cycle request pulses, one per requester (debounced push-button outputs).
REQ-006 req_data  input  32  per-requester byte; requester i owns bits [8i+7:8i].
REQ-007 clr_err  input  1  synchronous clear of overrun and timeout flags.
REQ-008 tx_busy  input  1  transmitter busy; high while a frame is shifting out.
REQ-009 tx_start  output  1  one-cycle load strobe to the transmitter.
REQ-010 tx_data  output  8  byte presented to the transmitter; valid while tx_start is high.
REQ-011 grant_id  output  2  index of the requester currently or last served.
REQ-012 pending  output  4  latched, unserved requests.
REQ-013 overrun  output  4  sticky: a request arrived while the same line was already pending.
REQ-014 tmo_err  output  1  sticky: tx_busy failed to rise within START_TMO cycles.

Function
REQ-015 req_pulse[i] high for one cycle SHALL set pending[i] on the next edge.
REQ-016 req_pulse[i] high while pending[i] is already 1 SHALL set overrun[i]; the request count stays at one.
REQ-017 pending[i] SHALL clear in the LOAD cycle that grants i; a req_pulse[i] in that same cycle SHALL leave pending[i]=1 (new request wins) without setting overrun[i].
REQ-018 FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
REQ-019 IDLE -> LOAD when any pending bit is 1; otherwise stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: search starts at (last grant_id + 1) mod 4; after reset the search starts at index 0.
REQ-021 LOAD SHALL last exactly one cycle, with tx_start=1, tx_data = req_data slice of the winner sampled that cycle, and grant_id = winner; then -> WAIT_BUSY.
REQ-022 tx_start SHALL be 0 in every state except LOAD; tx_data SHALL hold its last loaded value outside LOAD.
REQ-023 WAIT_BUSY -> WAIT_DONE on the first cycle tx_busy=1; the timeout counter counts cycles in WAIT_BUSY.
REQ-024 If tx_busy is still 0 after START_TMO cycles in WAIT_BUSY, the FSM SHALL set tmo_err and go to GAP; the request is not retried.
REQ-025 WAIT_DONE -> GAP on the first cycle tx_busy=0.
REQ-026 GAP SHALL last exactly GAP_CYCLES cycles, then -> IDLE; the gap counter reloads on every entry to GAP.
REQ-027 Requests arriving in any state SHALL be latched per REQ-015..017; none are lost except duplicates, which are flagged by overrun.
REQ-028 Minimum spacing from one tx_start to the next SHALL be 1 (LOAD) + 1 (WAIT_BUSY) + 1 (WAIT_DONE) + GAP_CYCLES + 1 (IDLE) cycles.
REQ-029 clr_err=1 SHALL clear overrun and tmo_err on the next edge; a set condition in the same cycle SHALL take priority (flag stays 1).
REQ-030 Counters SHALL be 8 bits wide and saturate; they SHALL never wrap inside a state.

Reset
REQ-031 With rst_n=0, the block SHALL asynchronously force: state IDLE, tx_start=0, tx_data=0, grant_id=0, pending=0, overrun=0, tmo_err=0, counters 0, round-robin pointer set so the next search starts at 0.
REQ-032 Deasserting reset mid-frame SHALL leave the block in IDLE, with no tx_start until a new req_pulse arrives.

Verification
REQ-033 Single request: req_pulse=0001, req_data[7:0]=0x41, tx_busy high for 10 cycles starting 2 cycles after tx_start -> exactly one tx_start, tx_data=0x41, grant_id=0, pending returns to 0000, then 16 gap cycles.
REQ-034 Simultaneous requests: req_pulse=1111 in one cycle, with a well-behaved transmitter model -> grant order 0,1,2,3; each tx_data matches its slice; each tx_start pair is separated per REQ-028.
REQ-035 Round-robin fairness: grant_id=2 just served and pending=0101 -> next grant is 0 (search order 3, 0, 1, ...). Pending requester 0 is served before requester 2.
REQ-036 Duplicate: req_pulse[1] twice while pending[1]=1 -> overrun=0010 and only one frame for requester 1; after clr_err=1, overrun=0000.
REQ-037 Timeout: tx_busy held at 0 -> tmo_err=1 exactly START_TMO cycles after WAIT_BUSY entry, then GAP, then the next pending request is served.
REQ-038 Reset mid-frame: assert rst_n=0 during WAIT_DONE with pending=1000 -> all outputs at reset values; after release, no tx_start occurs until a new req_pulse.
